vga_text_renderer: RTL and testbench

- Consumes the 25 MHz pixel clock and the 8-bit character buffer port of the SoC system; produces 640x480@60 Hz VGA for the board DAC.
- Generates raster timing, fetches the character code per 8x16 cell from the on-chip character RAM, looks up the glyph row in an external font ROM, and serialises pixels.
- Read-only master of the character RAM port; the HPS writes text via the other RAM port.

---
 rtl/vga_text_renderer.sv | 144 ++++++++++++++
 tb/tb_vga_text_renderer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_renderer.sv
// rtl/vga_text_renderer.sv - 640x480 VGA text-mode renderer: raster timing, char RAM fetch, font lookup, pixel serialiser
// Five-stage pipeline from raster counters to pins; sync/blank controls travel alongside the pixel data.
module vga_text_renderer #(
    parameter int          H_ACTIVE = 640,
    parameter int          H_FP     = 16,
    parameter int          H_SYNC   = 96,
    parameter int          H_BP     = 48,
    parameter int          V_ACTIVE = 480,
    parameter int          V_FP     = 10,
    parameter int          V_SYNC   = 2,
    parameter int          V_BP     = 33,
    parameter int          COLS     = 80,
    parameter logic [23:0] FG_RGB   = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB   = 24'h000000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    output logic [11:0] mem_address,
    output logic        mem_chipselect,
    output logic        mem_clken,
    output logic        mem_write,
    output logic [7:0]  mem_writedata,
    input  logic [7:0]  mem_readdata,
    output logic [11:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_blank_n,
    output logic        vga_sync_n,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;

    logic          de_s0, hs_s0, vs_s0, first_s0;
    logic [11:0]   addr_s0;

    // Syncs are carried active-high internally so all-zero reset keeps the pins deasserted.
    logic [3:0]      de_pipe_q, hs_pipe_q, vs_pipe_q, first_pipe_q;
    logic [3:0][2:0] bit_pipe_q;
    logic [1:0][3:0] row_pipe_q;

    logic [11:0] mem_address_q, font_addr_q;
    logic        mem_cs_q;
    logic [23:0] rgb_q, rgb_d;
    logic        hs_q, vs_q, blank_n_q, frame_start_q;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end
    end

    always_comb begin
        de_s0    = (h_q < H_ACT) && (v_q < V_ACT);
        hs_s0    = (h_q >= HS_BEG) && (h_q < HS_END);
        vs_s0    = (v_q >= VS_BEG) && (v_q < VS_END);
        first_s0 = (h_q == '0) && (v_q == '0);
        addr_s0  = de_s0 ? 12'(int'(v_q >> 4) * COLS + int'(h_q >> 3)) : 12'd0;
    end

    // Glyph MSB is the leftmost pixel of the cell.
    always_comb begin
        rgb_d = 24'h000000;
        if (de_pipe_q[3]) begin
            rgb_d = font_data[3'd7 - bit_pipe_q[3]] ? FG_RGB : BG_RGB;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            h_q           <= '0;
            v_q           <= '0;
            de_pipe_q     <= '0;
            hs_pipe_q     <= '0;
            vs_pipe_q     <= '0;
            first_pipe_q  <= '0;
            bit_pipe_q    <= '0;
            row_pipe_q    <= '0;
            mem_address_q <= '0;
            mem_cs_q      <= 1'b0;
            font_addr_q   <= '0;
            rgb_q         <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            de_pipe_q     <= {de_pipe_q[2:0], de_s0};
            hs_pipe_q     <= {hs_pipe_q[2:0], hs_s0};
            vs_pipe_q     <= {vs_pipe_q[2:0], vs_s0};
            first_pipe_q  <= {first_pipe_q[2:0], first_s0};
            bit_pipe_q    <= {bit_pipe_q[2:0], h_q[2:0]};
            row_pipe_q    <= {row_pipe_q[0], v_q[3:0]};
            mem_address_q <= addr_s0;
            mem_cs_q      <= de_s0;
            font_addr_q   <= {mem_readdata, row_pipe_q[1]};
            rgb_q         <= rgb_d;
            hs_q          <= ~hs_pipe_q[3];
            vs_q          <= ~vs_pipe_q[3];
            blank_n_q     <= de_pipe_q[3];
            frame_start_q <= first_pipe_q[3];
        end
    end

    assign mem_address    = mem_address_q;
    assign mem_chipselect = mem_cs_q;
    assign mem_clken      = 1'b1;
    assign mem_write      = 1'b0;
    assign mem_writedata  = 8'h00;
    assign font_addr      = font_addr_q;
    assign vga_r          = rgb_q[23:16];
    assign vga_g          = rgb_q[15:8];
    assign vga_b          = rgb_q[7:0];
    assign vga_hs         = hs_q;
    assign vga_vs         = vs_q;
    assign vga_blank_n    = blank_n_q;
    assign vga_sync_n     = 1'b0;
    assign frame_start    = frame_start_q;

endmodule

// File: tb/tb_vga_text_renderer.sv
// tb/tb_vga_text_renderer.sv - self-checking bench for vga_text_renderer
module tb_vga_text_renderer;

    logic clk = 1'b0;
    always #20 clk = ~clk;

    logic rst_n;
    logic [7:0] ram  [4096];
    logic [7:0] font [4096];

    logic [11:0] d_addr, d_fa, s_addr, s_fa;
    logic        d_cs, d_clken, d_wr, s_cs, s_clken, s_wr;
    logic [7:0]  d_wd, s_wd, d_rd, d_fd, s_rd, s_fd;
    logic [7:0]  d_r, d_g, d_b, s_r, s_g, s_b;
    logic        d_hs, d_vs, d_blank, d_syncn, d_fs;
    logic        s_hs, s_vs, s_blank, s_syncn, s_fs;

    always @(posedge clk) begin
        d_rd <= ram[d_addr];
        d_fd <= font[d_fa];
        s_rd <= ram[s_addr];
        s_fd <= font[s_fa];
    end

    vga_text_renderer u_def (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .mem_address(d_addr), .mem_chipselect(d_cs), .mem_clken(d_clken),
        .mem_write(d_wr), .mem_writedata(d_wd), .mem_readdata(d_rd),
        .font_addr(d_fa), .font_data(d_fd),
        .vga_r(d_r), .vga_g(d_g), .vga_b(d_b),
        .vga_hs(d_hs), .vga_vs(d_vs), .vga_blank_n(d_blank),
        .vga_sync_n(d_syncn), .frame_start(d_fs)
    );

    // Shrunken raster so whole frames fit in a short run; also exercises non-default colours.
    vga_text_renderer #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
        .V_ACTIVE(32), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .COLS(8), .FG_RGB(24'hFF0000), .BG_RGB(24'h0000FF)
    ) u_sm (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .mem_address(s_addr), .mem_chipselect(s_cs), .mem_clken(s_clken),
        .mem_write(s_wr), .mem_writedata(s_wd), .mem_readdata(s_rd),
        .font_addr(s_fa), .font_data(s_fd),
        .vga_r(s_r), .vga_g(s_g), .vga_b(s_b),
        .vga_hs(s_hs), .vga_vs(s_vs), .vga_blank_n(s_blank),
        .vga_sync_n(s_syncn), .frame_start(s_fs)
    );

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic        fs;
        logic [23:0] rgb;
        logic [11:0] addr;
        logic [3:0]  row;
    } exp_t;

    int checks   = 0;
    int failures = 0;
    int k        = 0;

    localparam exp_t IDLE = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, rgb: 24'h0, addr: 12'h0, row: 4'h0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s k=%0d obs=%h exp=%h", tag, k, obs, exp);
        end
    endtask

    // Screen position p pixels after (0,0), evaluated straight from the raster rules.
    function automatic exp_t model(input int p, input bit sm);
        int ha, hf, hw, hb, va, vf, vw, vb, cols, ht, vt, h, v;
        logic [23:0] fg, bg;
        logic [7:0]  g;
        exp_t m;
        if (sm) begin
            ha = 64; hf = 4; hw = 8; hb = 4; va = 32; vf = 2; vw = 2; vb = 2;
            cols = 8; fg = 24'hFF0000; bg = 24'h0000FF;
        end else begin
            ha = 640; hf = 16; hw = 96; hb = 48; va = 480; vf = 10; vw = 2; vb = 33;
            cols = 80; fg = 24'hFFFFFF; bg = 24'h000000;
        end
        ht = ha + hf + hw + hb;
        vt = va + vf + vw + vb;
        h  = p % ht;
        v  = (p / ht) % vt;
        m.de   = (h < ha) && (v < va);
        m.hs   = !((h >= ha + hf) && (h < ha + hf + hw));
        m.vs   = !((v >= va + vf) && (v < va + vf + vw));
        m.fs   = (h == 0) && (v == 0);
        m.addr = m.de ? 12'((v / 16) * cols + h / 8) : 12'd0;
        m.row  = 4'(v % 16);
        g      = font[{ram[m.addr], m.row}];
        m.rgb  = !m.de ? 24'h0 : (g[7 - (h % 8)] ? fg : bg);
        return m;
    endfunction

    task automatic check_cycle();
        exp_t o, a, f;
        o = (k >= 5) ? model(k - 5, 1'b0) : IDLE;
        a = (k >= 1) ? model(k - 1, 1'b0) : IDLE;
        chk("def_hs", d_hs, o.hs);
        chk("def_vs", d_vs, o.vs);
        chk("def_blank_n", d_blank, o.de);
        chk("def_frame_start", d_fs, o.fs);
        chk("def_rgb", {d_r, d_g, d_b}, o.rgb);
        chk("def_mem_address", d_addr, a.addr);
        chk("def_chipselect", d_cs, a.de);
        if (k >= 3) begin
            f = model(k - 3, 1'b0);
            chk("def_font_addr", d_fa, {ram[f.addr], f.row});
        end
        o = (k >= 5) ? model(k - 5, 1'b1) : IDLE;
        a = (k >= 1) ? model(k - 1, 1'b1) : IDLE;
        chk("sm_hs", s_hs, o.hs);
        chk("sm_vs", s_vs, o.vs);
        chk("sm_blank_n", s_blank, o.de);
        chk("sm_frame_start", s_fs, o.fs);
        chk("sm_rgb", {s_r, s_g, s_b}, o.rgb);
        chk("sm_mem_address", s_addr, a.addr);
        chk("sm_chipselect", s_cs, a.de);
        if (k >= 3) begin
            f = model(k - 3, 1'b1);
            chk("sm_font_addr", s_fa, {ram[f.addr], f.row});
        end
    endtask

    task automatic tick();
        @(negedge clk);
        k++;
        check_cycle();
    endtask

    task automatic chk_reset_pins(input string who);
        chk({who, "_rst_addr"}, d_addr, 12'd0);
        chk({who, "_rst_cs"}, d_cs, 1'b0);
        chk({who, "_rst_fa"}, d_fa, 12'd0);
        chk({who, "_rst_rgb"}, {d_r, d_g, d_b}, 24'h0);
        chk({who, "_rst_syncs"}, {d_hs, d_vs, d_blank, d_fs}, 4'b1100);
        chk({who, "_rst_sm_addr"}, s_addr, 12'd0);
        chk({who, "_rst_sm_rgb"}, {s_r, s_g, s_b}, 24'h0);
        chk({who, "_rst_sm_syncs"}, {s_hs, s_vs, s_blank, s_fs}, 4'b1100);
    endtask

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            ram[i]  = 8'($urandom);
            font[i] = 8'($urandom);
        end
        ram[0]                = 8'h41;
        font[{8'h41, 4'h0}]   = 8'b1000_0001;

        repeat (3) @(negedge clk);
        chk_reset_pins("init");
        chk("constants", {d_clken, d_wr, d_wd, d_syncn, s_clken, s_wr, s_wd, s_syncn},
            {1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0});
        check_cycle();

        rst_n = 1'b1;
        repeat (4) tick();
        chk("def_blank_before_first", d_blank, 1'b0);
        chk("def_fs_before_first", d_fs, 1'b0);
        tick();
        chk("def_fs_at_5", d_fs, 1'b1);
        chk("def_blank_rise_at_5", d_blank, 1'b1);
        chk("def_px0", {d_r, d_g, d_b}, 24'hFFFFFF);
        chk("sm_px0_fg", {s_r, s_g, s_b}, 24'hFF0000);
        for (int px = 1; px < 8; px++) begin
            tick();
            chk("def_glyph_px", {d_r, d_g, d_b}, (px == 7) ? 24'hFFFFFF : 24'h000000);
            chk("sm_glyph_px", {s_r, s_g, s_b}, (px == 7) ? 24'hFF0000 : 24'h0000FF);
        end

        while (k < 31 * 80 + 63 + 1) tick();
        chk("sm_addr_max", s_addr, 12'd15);
        tick();
        chk("sm_blank_addr", {s_cs, s_addr}, 13'd0);

        while (k < 16 * 800 + 8 + 1) tick();
        chk("def_addr_81", d_addr, 12'd81);

        while (k < 16 * 800 + 300) tick();
        @(posedge clk);
        #5 rst_n = 1'b0;
        #1 chk_reset_pins("async");

        k = 0;
        repeat (2) begin
            @(negedge clk);
            check_cycle();
        end
        rst_n = 1'b1;
        while (k < 2 * 3040 + 20) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
